// File: rtl/mem_access_initiator_if.sv
// -----------------------------------------------------------------------------
// mem_access_initiator_if
// Data-memory bus between the MEM-stage access initiator and a multi-cycle
// data memory.
//   bus_req    initiator -> memory  request strobe, held until bus_gnt
//   bus_we     initiator -> memory  1 = write
//   bus_addr   initiator -> memory  word-aligned byte address
//   bus_be     initiator -> memory  byte enables, bit n = lane n
//   bus_wdata  initiator -> memory  lane-replicated store data
//   bus_gnt    memory -> initiator  request accepted
//   bus_rvalid memory -> initiator  read data valid
//   bus_rdata  memory -> initiator  read word
// -----------------------------------------------------------------------------
interface mem_access_initiator_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_be,
        output bus_wdata,
        input  bus_gnt,
        input  bus_rvalid,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_be,
        input  bus_wdata,
        output bus_gnt,
        output bus_rvalid,
        output bus_rdata
    );
endinterface

// File: rtl/mem_access_initiator.sv
// -----------------------------------------------------------------------------
// mem_access_initiator
// Requester side of the MIPS data-memory interface (MEM stage). Takes one
// load/store at a time from EX/MEM, rejects misaligned accesses, issues a
// word-addressed request with byte enables, waits for grant (and read data for
// loads), then returns the extended load result and releases the stall.
// Parameter:
//   TIMEOUT     cycles allowed in REQ+RESP before abort with bus_err (2..255)
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   i_op_valid  EX/MEM presents an access
//   i_mem_op    MemControl code
//   i_addr      byte address
//   i_wdata     store data
//   o_op_ready  high only in IDLE; pipeline stalls while low
//   o_done      one-cycle pulse on successful completion
//   o_rdata     extended load result, held until the next load completes
//   o_addr_err  one-cycle pulse for a misaligned access
//   o_bus_err   one-cycle pulse on timeout
//   bus         data-memory bus (master side)
// -----------------------------------------------------------------------------
module mem_access_initiator #(
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_op_valid,
    input  logic [3:0]            i_mem_op,
    input  logic [31:0]           i_addr,
    input  logic [31:0]           i_wdata,
    output logic                  o_op_ready,
    output logic                  o_done,
    output logic [31:0]           o_rdata,
    output logic                  o_addr_err,
    output logic                  o_bus_err,
    mem_access_initiator_if.master bus
);

    // MemControl codes
    localparam logic [3:0] MEM_LW  = 4'd1;
    localparam logic [3:0] MEM_LB  = 4'd2;
    localparam logic [3:0] MEM_LH  = 4'd3;
    localparam logic [3:0] MEM_LBU = 4'd4;
    localparam logic [3:0] MEM_LHU = 4'd5;
    localparam logic [3:0] MEM_SW  = 4'd6;
    localparam logic [3:0] MEM_SH  = 4'd7;
    localparam logic [3:0] MEM_SB  = 4'd8;

    // The counter is compared before its increment, so the last allowed
    // cycle is the one where it still reads TIMEOUT-1.
    localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_accept;
    logic        w_misalign;
    logic        w_timeout;

    logic [3:0]  r_op;
    logic [1:0]  r_lane;
    logic [7:0]  r_cnt;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [3:0]  r_bus_be;
    logic [31:0] r_bus_wdata;
    logic [31:0] r_rdata;
    logic        r_addr_err;
    logic        r_bus_err;

    function automatic logic f_is_known(input logic [3:0] op);
        case (op)
            MEM_LW, MEM_LB, MEM_LH, MEM_LBU, MEM_LHU,
            MEM_SW, MEM_SH, MEM_SB: f_is_known = 1'b1;
            default:                f_is_known = 1'b0;
        endcase
    endfunction

    function automatic logic f_is_store(input logic [3:0] op);
        f_is_store = (op == MEM_SW) || (op == MEM_SH) || (op == MEM_SB);
    endfunction

    function automatic logic f_misaligned(input logic [3:0] op, input logic [1:0] lane);
        case (op)
            MEM_LW, MEM_SW:          f_misaligned = (lane != 2'b00);
            MEM_LH, MEM_LHU, MEM_SH: f_misaligned = lane[0];
            default:                 f_misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] f_be(input logic [3:0] op, input logic [1:0] lane);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: f_be = 4'b0001 << lane;
            MEM_LH, MEM_LHU, MEM_SH: f_be = lane[1] ? 4'b1100 : 4'b0011;
            default:                 f_be = 4'b1111;
        endcase
    endfunction

    // Stores replicate the datum into every lane so the memory only needs the
    // byte enables to place it; loads drive zero.
    function automatic logic [31:0] f_wdata(input logic [3:0] op, input logic [31:0] wd);
        case (op)
            MEM_SB:  f_wdata = {4{wd[7:0]}};
            MEM_SH:  f_wdata = {2{wd[15:0]}};
            MEM_SW:  f_wdata = wd;
            default: f_wdata = 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] f_extract(input logic [3:0] op, input logic [1:0] lane,
                                              input logic [31:0] word);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] s_byte;
        logic signed [31:0] s_half;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h      = lane[1] ? word[31:16] : word[15:0];
        s_byte = b;
        s_half = h;
        case (op)
            MEM_LB:  f_extract = s_byte;
            MEM_LBU: f_extract = {24'h0, b};
            MEM_LH:  f_extract = s_half;
            MEM_LHU: f_extract = {16'h0, h};
            default: f_extract = word;
        endcase
    endfunction

    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_misalign = 1'b0;
        w_timeout  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_op_valid && f_is_known(i_mem_op)) begin
                    if (f_misaligned(i_mem_op, i_addr[1:0])) begin
                        w_misalign = 1'b1;
                    end else begin
                        w_accept = 1'b1;
                        w_next   = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // A grant on the final allowed cycle still completes.
                if (bus.bus_gnt) begin
                    w_next = f_is_store(r_op) ? S_DONE : S_RESP;
                end else if (r_cnt >= LP_CNT_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_RESP: begin
                if (bus.bus_rvalid) begin
                    w_next = S_DONE;
                end else if (r_cnt >= LP_CNT_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op        <= 4'h0;
            r_lane      <= 2'b00;
            r_cnt       <= 8'h0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'h0;
            r_bus_be    <= 4'h0;
            r_bus_wdata <= 32'h0;
            r_rdata     <= 32'h0;
            r_addr_err  <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_addr_err <= w_misalign;
            r_bus_err  <= w_timeout;
            if (w_accept) begin
                r_op        <= i_mem_op;
                r_lane      <= i_addr[1:0];
                r_cnt       <= 8'h0;
                r_bus_we    <= f_is_store(i_mem_op);
                r_bus_addr  <= {i_addr[31:2], 2'b00};
                r_bus_be    <= f_be(i_mem_op, i_addr[1:0]);
                r_bus_wdata <= f_wdata(i_mem_op, i_wdata);
            end else if (r_state == S_REQ || r_state == S_RESP) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (r_state == S_RESP && bus.bus_rvalid) begin
                r_rdata <= f_extract(r_op, r_lane, bus.bus_rdata);
            end
        end
    end

    assign o_op_ready    = (r_state == S_IDLE);
    assign o_done        = (r_state == S_DONE);
    assign o_rdata       = r_rdata;
    assign o_addr_err    = r_addr_err;
    assign o_bus_err     = r_bus_err;
    assign bus.bus_req   = (r_state == S_REQ);
    assign bus.bus_we    = r_bus_we;
    assign bus.bus_addr  = r_bus_addr;
    assign bus.bus_be    = r_bus_be;
    assign bus.bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_mem_access_initiator.sv
// -----------------------------------------------------------------------------
// tb_mem_access_initiator
// Directed stimulus with a scoreboard: each issued op pushes its expected bus
// request and its expected completion event; a monitor compares them whenever
// the DUT raises bus_req or done/addr_err/bus_err. A small responder model
// plays the memory (configurable grant delay, never-grant, read-data hold).
// -----------------------------------------------------------------------------
module tb_mem_access_initiator;
  localparam int TO = 4;

  localparam logic [3:0] MEM_LW  = 4'd1;
  localparam logic [3:0] MEM_LB  = 4'd2;
  localparam logic [3:0] MEM_LH  = 4'd3;
  localparam logic [3:0] MEM_LBU = 4'd4;
  localparam logic [3:0] MEM_LHU = 4'd5;
  localparam logic [3:0] MEM_SW  = 4'd6;
  localparam logic [3:0] MEM_SH  = 4'd7;
  localparam logic [3:0] MEM_SB  = 4'd8;

  localparam logic [31:0] K_DONE = 32'd1;
  localparam logic [31:0] K_AERR = 32'd2;
  localparam logic [31:0] K_BERR = 32'd4;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    logic [31:0] kind;
    logic [31:0] rdata;
  } rsp_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [3:0]  mem_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        op_ready;
  logic        done;
  logic [31:0] rdata;
  logic        addr_err;
  logic        bus_err;

  bus_exp_t bus_q[$];
  rsp_exp_t rsp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // responder controls
  logic        gnt_never = 1'b0;
  int          gnt_delay = 0;
  logic        rv_block  = 1'b0;
  logic [31:0] rd_word   = 32'h1234_80FF;
  int          req_seen  = 0;
  logic        pend      = 1'b0;

  // monitor state
  logic        prev_req = 1'b0;
  int          run = 0;
  int          last_run = 0;
  bus_exp_t    cur;
  rsp_exp_t    rexp;
  logic [31:0] exp_last = 32'h0;

  always #5 clk = ~clk;

  mem_access_initiator_if bus_if ();

  mem_access_initiator #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_op_valid (op_valid),
    .i_mem_op   (mem_op),
    .i_addr     (addr),
    .i_wdata    (wdata),
    .o_op_ready (op_ready),
    .o_done     (done),
    .o_rdata    (rdata),
    .o_addr_err (addr_err),
    .o_bus_err  (bus_err),
    .bus        (bus_if)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_bus(input logic [31:0] a, input logic [3:0] be, input logic we,
                         input logic [31:0] wd);
    bus_exp_t e;
    e.addr = a; e.be = be; e.we = we; e.wdata = wd;
    bus_q.push_back(e);
  endtask

  task automatic exp_rsp(input logic [31:0] kind, input logic [31:0] rd);
    rsp_exp_t e;
    e.kind = kind; e.rdata = rd;
    rsp_q.push_back(e);
  endtask

  task automatic issue(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] wd, input logic exp_ready);
    int w = 0;
    @(negedge clk);
    while (!op_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!op_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: op_ready never rose", name);
    end
    op_valid = 1'b1; mem_op = op; addr = a; wdata = wd;
    @(posedge clk);
    #1;
    op_valid = 1'b0; mem_op = 4'h0; addr = 32'h0; wdata = 32'h0;
    chk({name, "_ready_after"}, {31'h0, op_ready}, {31'h0, exp_ready});
  endtask

  task automatic drain(input string name);
    int w = 0;
    while ((rsp_q.size() != 0 || bus_q.size() != 0 || !op_ready) && w < 60) begin
      @(negedge clk);
      w++;
    end
    n_tests++;
    if (w >= 60) begin
      n_fail++;
      $display("FAIL %s_drain: pending rsp %0d bus %0d required 0 0", name, rsp_q.size(), bus_q.size());
      rsp_q.delete();
      bus_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Memory responder: inputs change #1 after posedge so they are stable at
  // both the sampling negedge and the next active edge.
  initial begin
    bus_if.bus_gnt    = 1'b0;
    bus_if.bus_rvalid = 1'b0;
    bus_if.bus_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      if (bus_if.bus_req && bus_if.bus_gnt && !bus_if.bus_we) pend = 1'b1;
      if (bus_if.bus_req && !bus_if.bus_gnt) req_seen++;
      else req_seen = 0;
      @(posedge clk);
      #1;
      bus_if.bus_rvalid = pend && !rv_block && !rst;
      bus_if.bus_rdata  = bus_if.bus_rvalid ? rd_word : 32'h5A5A_5A5A;
      if (bus_if.bus_rvalid) pend = 1'b0;
      bus_if.bus_gnt = bus_if.bus_req && !gnt_never && (req_seen >= gnt_delay);
    end
  end

  // Monitor / scoreboard checker
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_req = 1'b0;
        run = 0;
        continue;
      end
      if (bus_if.bus_req) begin
        if (!prev_req) begin
          if (bus_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_req: bus_req=1 addr %h required no request", bus_if.bus_addr);
            cur.addr = 32'hx; cur.be = 4'hx; cur.we = 1'bx; cur.wdata = 32'hx;
          end else begin
            cur = bus_q.pop_front();
          end
        end
        chk("bus_addr", bus_if.bus_addr, cur.addr);
        chk("bus_be", {28'h0, bus_if.bus_be}, {28'h0, cur.be});
        chk("bus_we", {31'h0, bus_if.bus_we}, {31'h0, cur.we});
        if (cur.we) chk("bus_wdata", bus_if.bus_wdata, cur.wdata);
        run++;
      end else if (prev_req) begin
        last_run = run;
        run = 0;
      end
      prev_req = bus_if.bus_req;
      if (done || addr_err || bus_err) begin
        if (rsp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_event: done %b addr_err %b bus_err %b required none",
                   done, addr_err, bus_err);
        end else begin
          rexp = rsp_q.pop_front();
          chk("event_kind", {29'h0, bus_err, addr_err, done}, rexp.kind);
          if (done) chk("rdata", rdata, rexp.rdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; op_valid = 1'b0; mem_op = 4'h0; addr = 32'h0; wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_op_ready", {31'h0, op_ready}, 32'd1);
    chk("rst_done", {31'h0, done}, 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_bus_req", {31'h0, bus_if.bus_req}, 32'd0);
    chk("rst_bus_addr", bus_if.bus_addr, 32'h0);
    chk("rst_bus_be", {28'h0, bus_if.bus_be}, 32'h0);
    chk("rst_bus_wdata", bus_if.bus_wdata, 32'h0);
    chk("rst_errs", {30'h0, addr_err, bus_err}, 32'h0);
    rst = 1'b0;

    // stores, immediate grant
    exp_bus(32'h104, 4'b1111, 1'b1, 32'hDEAD_BEEF); exp_rsp(K_DONE, exp_last);
    issue("sw", MEM_SW, 32'h0000_0104, 32'hDEAD_BEEF, 1'b0); drain("sw");
    chk("sw_req_cycles", last_run, 32'd1);
    exp_bus(32'h10, 4'b1000, 1'b1, 32'hA5A5_A5A5); exp_rsp(K_DONE, exp_last);
    issue("sb", MEM_SB, 32'h0000_0013, 32'h0000_00A5, 1'b0); drain("sb");
    exp_bus(32'h10, 4'b1100, 1'b1, 32'h1357_1357); exp_rsp(K_DONE, exp_last);
    issue("sh", MEM_SH, 32'h0000_0012, 32'hCAFE_1357, 1'b0); drain("sh");

    // loads from word 0x1234_80FF
    exp_last = 32'hFFFF_FF80; exp_bus(32'h20, 4'b0010, 1'b0, 32'h0); exp_rsp(K_DONE, exp_last);
    issue("lb", MEM_LB, 32'h21, 32'h0, 1'b0); drain("lb");
    exp_last = 32'h0000_0080; exp_bus(32'h20, 4'b0010, 1'b0, 32'h0); exp_rsp(K_DONE, exp_last);
    issue("lbu", MEM_LBU, 32'h21, 32'h0, 1'b0); drain("lbu");
    exp_last = 32'h0000_1234; exp_bus(32'h20, 4'b1100, 1'b0, 32'h0); exp_rsp(K_DONE, exp_last);
    issue("lh", MEM_LH, 32'h22, 32'h0, 1'b0); drain("lh");
    exp_last = 32'h0000_80FF; exp_bus(32'h20, 4'b0011, 1'b0, 32'h0); exp_rsp(K_DONE, exp_last);
    issue("lhu", MEM_LHU, 32'h20, 32'h0, 1'b0); drain("lhu");
    exp_last = 32'hFFFF_80FF; exp_bus(32'h20, 4'b0011, 1'b0, 32'h0); exp_rsp(K_DONE, exp_last);
    issue("lh_neg", MEM_LH, 32'h20, 32'h0, 1'b0); drain("lh_neg");
    exp_last = 32'h0000_0012; exp_bus(32'h20, 4'b1000, 1'b0, 32'h0); exp_rsp(K_DONE, exp_last);
    issue("lb_lane3", MEM_LB, 32'h23, 32'h0, 1'b0); drain("lb_lane3");
    exp_last = 32'h1234_80FF; exp_bus(32'h24, 4'b1111, 1'b0, 32'h0); exp_rsp(K_DONE, exp_last);
    issue("lw", MEM_LW, 32'h24, 32'h0, 1'b0); drain("lw");
    // store after load leaves rdata untouched
    exp_bus(32'h30, 4'b0100, 1'b1, 32'h7777_7777); exp_rsp(K_DONE, exp_last);
    issue("sb_hold", MEM_SB, 32'h32, 32'hFFFF_FF77, 1'b0); drain("sb_hold");

    // misaligned accesses: addr_err, no bus activity, ready stays high
    exp_rsp(K_AERR, 32'h0); issue("lw_mis", MEM_LW, 32'h2, 32'h0, 1'b1); drain("lw_mis");
    exp_rsp(K_AERR, 32'h0); issue("lh_mis", MEM_LH, 32'h3, 32'h0, 1'b1); drain("lh_mis");
    exp_rsp(K_AERR, 32'h0); issue("sw_mis", MEM_SW, 32'h1, 32'h0, 1'b1); drain("sw_mis");
    exp_rsp(K_AERR, 32'h0); issue("sh_mis", MEM_SH, 32'h41, 32'h0, 1'b1); drain("sh_mis");
    // unknown opcode is ignored
    issue("unknown_op", 4'hF, 32'h100, 32'h0, 1'b1); drain("unknown_op");

    // timeout: never granted
    gnt_never = 1'b1;
    exp_bus(32'h40, 4'b1111, 1'b0, 32'h0); exp_rsp(K_BERR, 32'h0);
    issue("timeout", MEM_LW, 32'h40, 32'h0, 1'b0); drain("timeout");
    chk("timeout_req_cycles", last_run, TO);
    chk("timeout_rdata_kept", rdata, exp_last);
    gnt_never = 1'b0;

    // grant on the last allowed cycle wins over timeout
    gnt_delay = TO - 1;
    exp_bus(32'h44, 4'b1111, 1'b1, 32'h1122_3344); exp_rsp(K_DONE, exp_last);
    issue("late_gnt", MEM_SW, 32'h44, 32'h1122_3344, 1'b0); drain("late_gnt");
    chk("late_gnt_req_cycles", last_run, TO);
    gnt_delay = 0;

    // reset during RESP of a load
    rv_block = 1'b1;
    exp_bus(32'h48, 4'b1111, 1'b0, 32'h0);
    issue("rst_mid", MEM_LW, 32'h48, 32'h0, 1'b0);
    begin
      int w = 0;
      while ((bus_if.bus_req || op_ready) && w < 20) begin
        @(negedge clk);
        w++;
      end
      chk("rst_mid_reach_resp", {31'h0, bus_if.bus_req | op_ready}, 32'd0);
    end
    rst = 1'b1;
    #1;
    chk("rst_mid_bus_req", {31'h0, bus_if.bus_req}, 32'd0);
    chk("rst_mid_done", {31'h0, done}, 32'd0);
    chk("rst_mid_rdata", rdata, 32'h0);
    chk("rst_mid_op_ready", {31'h0, op_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0; rv_block = 1'b0; pend = 1'b0; exp_last = 32'h0;
    rd_word = 32'hCAFE_F00D;
    exp_last = 32'hCAFE_F00D; exp_bus(32'h4C, 4'b1111, 1'b0, 32'h0); exp_rsp(K_DONE, exp_last);
    issue("lw_after_rst", MEM_LW, 32'h4C, 32'h0, 1'b0); drain("lw_after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
